// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed hex 7-segment scanner with frame-synchronous value swap and leading-zero blanking
module seg7_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 100000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic                    LzbEn,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  output logic [6:0]              out7,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    Pending,
  output logic                    FrameDone
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  // abcdefg patterns, digit 0 in the least significant 7 bits
  localparam logic [111:0] SEG_LUT = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp, pend_val;
  logic                    tc, wrap, blank, z;
  logic [NUM_DIGITS-1:0]   lz, en_n;
  logic [3:0]              nib;
  logic [6:0]              seg_n;
  logic                    dp_n;
  assign tc = presc == PW'(SCAN_DIV - 1);
  assign wrap = tc && idx == IW'(NUM_DIGITS - 1);
  assign nib = disp[4*idx +: 4];
  // lz[i]: nibbles i..top of the display register are all zero
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && disp[4*i +: 4] == 4'd0;
      lz[i] = z;
    end
  end
  always_comb begin
    blank = BlankMask[idx] || (LzbEn && idx != '0 && lz[idx]);
    en_n = blank ? '0 : NUM_DIGITS'(1) << idx;
    seg_n = blank ? 7'd0 : SEG_LUT[7*nib +: 7];
    dp_n = !blank && DpMask[idx];
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc <= '0;
      idx <= '0;
      disp <= '0;
      pend_val <= '0;
      Pending <= 1'b0;
      FrameDone <= 1'b0;
      out7 <= {7{ACTIVE_LOW}};
      dp <= ACTIVE_LOW;
      en_out <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      presc <= tc ? '0 : presc + PW'(1);
      idx <= !tc ? idx : wrap ? '0 : idx + IW'(1);
      FrameDone <= wrap;
      out7 <= seg_n ^ {7{ACTIVE_LOW}};
      dp <= dp_n ^ ACTIVE_LOW;
      en_out <= en_n ^ {NUM_DIGITS{ACTIVE_LOW}};
      // a load on the wrap cycle bypasses the pending register entirely
      if (Load && wrap) begin
        disp <= Value;
        Pending <= 1'b0;
      end else if (Load) begin
        pend_val <= Value;
        Pending <= 1'b1;
      end else if (wrap && Pending) begin
        disp <= pend_val;
        Pending <= 1'b0;
      end
    end
  end
endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of Clock.
REQ-002 Parameter NUM_DIGITS, default 8: number of multiplexed digits; legal range 1..16.
REQ-003 Parameter SCAN_DIV, default 100000: Clock cycles each digit is held; legal range >= 1.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means segment and enable outputs are active-low; 0 means active-high.
REQ-005 Clock  in  1  system clock.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 Value  in  4*NUM_DIGITS  hex digits; nibble i drives digit i; digit 0 = Value[3:0] = rightmost.
REQ-008 Load  in  1  single-cycle strobe that captures Value.
REQ-009 LzbEn  in  1  leading-zero blanking enable, sampled every cycle.
REQ-010 BlankMask  in  NUM_DIGITS  bit i=1 forces digit i blank.
REQ-011 DpMask  in  NUM_DIGITS  bit i=1 lights the decimal point on digit i.
REQ-012 out7  out  7  segments; out7[6]=a through out7[0]=g.
REQ-013 dp  out  1  decimal-point segment.
REQ-014 en_out  out  NUM_DIGITS  digit enables; at most one active per cycle.
REQ-015 Pending  out  1  high while a loaded value waits for the frame boundary.
REQ-016 FrameDone  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Function
REQ-017 Prescaler counts 0..SCAN_DIV-1 and wraps; digit index advances by 1 on the prescaler terminal count, and wraps from NUM_DIGITS-1 to 0.
REQ-018 A "wrap cycle" is a prescaler terminal count with index = NUM_DIGITS-1; FrameDone SHALL be registered high for exactly the cycle after each wrap cycle.
REQ-019 Load outside a wrap cycle: Value goes to a pending register and Pending=1; a further Load before the boundary overwrites the pending register (last wins).
REQ-020 At a wrap cycle with Pending=1 and no Load: pending register copies to display register; Pending clears.
REQ-021 Load during a wrap cycle: Value goes directly to display register; Pending=0; any older pending value is discarded.
REQ-022 Digit i is blank if BlankMask[i]=1, or if LzbEn=1, i>0, and nibbles i..NUM_DIGITS-1 of the display register are all zero; digit 0 is never blanked by LZB.
REQ-023 Blank digit: its en_out slot inactive, out7 all-off, dp off, for its whole time slot.
REQ-024 Hex decode, active-high (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-025 ACTIVE_LOW=1 inverts out7, dp and en_out relative to the active-high form.
REQ-026 out7, dp and en_out SHALL be registered and reflect the index, display register and masks of the previous cycle (latency 1).
REQ-027 SCAN_DIV=1 SHALL advance the index every cycle with no idle cycles; NUM_DIGITS=1 SHALL make every terminal count a wrap cycle.

Reset
REQ-028 While Reset=1: prescaler=0, index=0, display and pending registers=0, Pending=0, FrameDone=0, en_out all inactive, out7 and dp off (all 1s when ACTIVE_LOW=1).
REQ-029 Reset asserted mid-frame or with Pending=1 SHALL discard the pending value, with no swap.
REQ-030 In the first cycle after Reset deasserts, outputs SHALL show digit 0 of the zeroed display register: "0", en_out[0] active.

Verification (NUM_DIGITS=8, SCAN_DIV=4, ACTIVE_LOW=0 unless noted)
REQ-031 Reset release, no Load -> en_out walks 0x01,0x02,...,0x80,0x01, each held 4 cycles; out7=1111110 on every digit; FrameDone pulses every 32 cycles.
REQ-032 Load Value=0x0000_00A5 mid-frame, LzbEn=1 -> Pending=1 until the wrap; next frame shows digit0=1011011, digit1=1110111, digits 2..7 blank; Pending=0.
REQ-033 Load 0x1111_1111 then 0x2222_2222 in the same frame -> only 2s are ever displayed.
REQ-034 Load 0x0000_0007 exactly on the wrap cycle -> digit 0 of the immediately following frame shows 1110000; Pending never asserts.
REQ-035 BlankMask=0x0F, DpMask=0x10, Value=0x8888_8888 -> digits 0..3 enable-off; digit 4 shows 1111111 with dp=1; ACTIVE_LOW=1 rerun -> all outputs bit-inverted.
REQ-036 Reset pulse while Pending=1 at index 5 -> outputs all-off during reset; display shows 0 afterwards; the pending value is never shown.
